// File: rtl/pa_ifu_sram_pkg.sv
// Shared types and constants for the IFU single-port SRAM controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pa_ifu_sram_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 47;

  // Widest bit-write-enable vector the helper below can describe.
  localparam int WEN_MAX = 1024;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_INV  = 2'b10
  } sram_state_e;

  // All-ones (inactive) bit write enable of width n, right-aligned in WEN_MAX bits.
  function automatic logic [WEN_MAX-1:0] wen_idle(input int n);
    logic [WEN_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < WEN_MAX; i++) begin
      if (i < n) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/pa_ifu_spsram_ctrl.sv
// Single-port SRAM initiator: reset/invalidate sweeps plus a valid/ready read/write port.
// Latency: read data one cycle after acceptance; sweeps take 2**ADDR_WIDTH cycles.
// Backpressure: req_rdy low during reset, sweeps, and any IDLE cycle with inv_req asserted.
module pa_ifu_spsram_ctrl
  import pa_ifu_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = {DATA_WIDTH{1'b0}}
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  inv_req,
  output logic                  inv_busy,
  input  logic                  req_vld,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  req_rdy,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [WEN_MAX-1:0]    WEN_VEC  = wen_idle(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] WEN_IDLE = WEN_VEC[DATA_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  sram_state_e           state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] hold;
  logic                  acc_rd;

  // SRAM pin drive and request handshake; reset forces every pin inactive.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = WEN_IDLE;
    sram_a    = '0;
    sram_d    = '0;
    req_rdy   = 1'b0;
    inv_busy  = 1'b1;
    acc_rd    = 1'b0;
    if (!cpurst) begin
      if (state != ST_IDLE) begin
        // Sweep: full-width write of INIT_VAL to entry cnt.
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt;
        sram_d    = INIT_VAL;
      end else begin
        inv_busy = 1'b0;
        // An invalidate request takes the cycle; no access is issued alongside it.
        req_rdy  = ~inv_req;
        if (req_vld && !inv_req) begin
          sram_cen = 1'b0;
          sram_a   = req_addr;
          if (req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~req_wmask;
            sram_d    = req_wdata;
          end else begin
            acc_rd = 1'b1;
          end
        end
      end
    end
  end

  // Sweep sequencing: INIT after reset, INV on request, IDLE in between.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT, ST_INV: begin
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          if (inv_req) state <= ST_INV;
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Read response: one-cycle valid pulse, and capture of Q for the hold value.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rsp_vld <= 1'b0;
      hold    <= '0;
    end else begin
      rsp_vld <= acc_rd;
      if (rsp_vld) hold <= sram_q;
    end
  end

  // Q passes straight through in the response cycle so no extra latency is added.
  assign rsp_data = rsp_vld ? sram_q : hold;

endmodule
